// File: rtl/gat_layer_scheduler.sv
// Sequences the GAT conv layers: waits for BRAM loads, pulses start, and times each layer.
// All outputs are registered, one cycle after the sampled input; nothing stalls, and a hung layer ends in ERR.
module gat_layer_scheduler #(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               h_data_bram_load_done,
  input  logic               h_node_info_bram_load_done,
  input  logic               wgt_bram_load_done,
  input  logic               layer_first_out_i,
  input  logic               layer_done_i,
  output logic               layer_start_o,
  output logic [LAYER_W-1:0] gat_layer_o,
  output logic               load_req_o,
  output logic               layer_ready_o,
  output logic               gat_ready_o,
  output logic               error_o,
  output logic [CNT_W-1:0]   dbg_latency_o,
  output logic [CNT_W-1:0]   dbg_total_o
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_LOAD   = 3'd1;
  localparam logic [2:0] S_START       = 3'd2;
  localparam logic [2:0] S_RUN         = 3'd3;
  localparam logic [2:0] S_NEXT        = 3'd4;
  localparam logic [2:0] S_WAIT_UNLOAD = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;
  localparam logic [2:0] S_ERR         = 3'd7;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_reg;
  logic             fo_seen;
  logic             all_ld;
  logic             none_ld;

  assign all_ld  = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
  assign none_ld = ~(h_data_bram_load_done | h_node_info_bram_load_done | wgt_bram_load_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_reg       <= '0;
      fo_seen       <= 1'b0;
      layer_start_o <= 1'b0;
      gat_layer_o   <= '0;
      load_req_o    <= 1'b0;
      layer_ready_o <= 1'b0;
      gat_ready_o   <= 1'b0;
      error_o       <= 1'b0;
      dbg_latency_o <= '0;
      dbg_total_o   <= '0;
    end else begin
      layer_start_o <= 1'b0;
      layer_ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          state      <= S_WAIT_LOAD;
          load_req_o <= 1'b1;
        end
        S_WAIT_LOAD: begin
          if (all_ld) begin
            state         <= S_START;
            layer_start_o <= 1'b1;
            load_req_o    <= 1'b0;
          end
        end
        S_START: begin
          cnt     <= '0;
          fo_seen <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (layer_first_out_i && !fo_seen) begin
            lat_reg <= cnt;
            fo_seen <= 1'b1;
          end
          // Done takes priority over a timeout landing in the same cycle.
          if (layer_done_i) begin
            dbg_total_o   <= cnt;
            dbg_latency_o <= fo_seen ? lat_reg : cnt;
            layer_ready_o <= 1'b1;
            state         <= (gat_layer_o == LAST_LAYER) ? S_DONE : S_NEXT;
          end else if (cnt == CNT_LAST) begin
            error_o <= 1'b1;
            state   <= S_ERR;
          end
        end
        S_NEXT: begin
          gat_layer_o <= gat_layer_o + LAYER_W'(1);
          load_req_o  <= 1'b1;
          state       <= S_WAIT_UNLOAD;
        end
        S_WAIT_UNLOAD: begin
          // Loads must fully drop first so a stale image cannot start the next layer.
          if (none_ld) begin
            state <= S_WAIT_LOAD;
          end
        end
        S_DONE: begin
          gat_ready_o <= 1'b1;
        end
        S_ERR: begin
          error_o     <= 1'b1;
          gat_ready_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Scoreboarded bench for gat_layer_scheduler: stimulus predicts events, a negedge monitor checks them.
module tb_gat_layer_scheduler;
  localparam int NL = 2;
  localparam int LW = 1;
  localparam int TO = 200;
  localparam int CW = 32;

  localparam int EV_START = 0;
  localparam int EV_READY = 1;
  localparam int EV_GAT   = 2;
  localparam int EV_ERR   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_ld = 1'b0, n_ld = 1'b0, w_ld = 1'b0;
  logic          fo = 1'b0, done = 1'b0;
  logic          layer_start_o;
  logic [LW-1:0] gat_layer_o;
  logic          load_req_o;
  logic          layer_ready_o;
  logic          gat_ready_o;
  logic          error_o;
  logic [CW-1:0] dbg_latency_o;
  logic [CW-1:0] dbg_total_o;

  gat_layer_scheduler #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(n_ld), .wgt_bram_load_done(w_ld),
    .layer_first_out_i(fo), .layer_done_i(done),
    .layer_start_o(layer_start_o), .gat_layer_o(gat_layer_o), .load_req_o(load_req_o),
    .layer_ready_o(layer_ready_o), .gat_ready_o(gat_ready_o), .error_o(error_o),
    .dbg_latency_o(dbg_latency_o), .dbg_total_o(dbg_total_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int cyc;
    int layer;
    int lat;
    int tot;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state: debug values the DUT should be showing.
  int last_lat = 0;
  int last_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int layer, input int lat, input int tot);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", kind, e.kind);
    chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
    chk($sformatf("ev%0d_layer", e.kind), layer, e.layer);
    chk($sformatf("ev%0d_latency", e.kind), lat, e.lat);
    chk($sformatf("ev%0d_total", e.kind), tot, e.tot);
  endtask

  logic gr_q = 1'b0, er_q = 1'b0;
  always @(negedge clk) begin
    if (layer_start_o) observe(EV_START, int'(gat_layer_o), int'(dbg_latency_o), int'(dbg_total_o));
    if (layer_ready_o) observe(EV_READY, int'(gat_layer_o), int'(dbg_latency_o), int'(dbg_total_o));
    if (gat_ready_o && !gr_q) observe(EV_GAT, int'(gat_layer_o), int'(dbg_latency_o), int'(dbg_total_o));
    if (error_o && !er_q) observe(EV_ERR, int'(gat_layer_o), int'(dbg_latency_o), int'(dbg_total_o));
    gr_q = gat_ready_o;
    er_q = error_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loads(input logic [2:0] v);
    {h_ld, n_ld, w_ld} = v;
  endtask

  task automatic push(input int kind, input int c, input int layer);
    ev_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.layer = layer;
    e.lat   = last_lat;
    e.tot   = last_tot;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    loads(3'b000);
    fo = 1'b0;
    done = 1'b0;
    tick();
    last_lat = 0;
    last_tot = 0;
    chk("rst_layer_start", int'(layer_start_o), 0);
    chk("rst_gat_layer", int'(gat_layer_o), 0);
    chk("rst_load_req", int'(load_req_o), 0);
    chk("rst_layer_ready", int'(layer_ready_o), 0);
    chk("rst_gat_ready", int'(gat_ready_o), 0);
    chk("rst_error", int'(error_o), 0);
    chk("rst_dbg_latency", int'(dbg_latency_o), 0);
    chk("rst_dbg_total", int'(dbg_total_o), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("wait_load_req", int'(load_req_o), 1);
  endtask

  // Layer timeline: loads complete in cycle t, start pulse t+1, run index k lives in cycle t+2+k.
  // f > d means no first-output pulse before done.
  task automatic run_layer(input int layer, input int f, input int d, input bit last);
    int t;
    loads(3'b111);
    t = cyc;
    push(EV_START, t + 1, layer);
    tick();
    chk("load_req_drop_at_start", int'(load_req_o), 0);
    tick();
    for (int k = 0; k <= d; k++) begin
      fo = (k == f) || (k > f && $urandom_range(0, 3) == 0);
      done = (k == d);
      if (k == d) begin
        last_lat = (f <= d) ? f : d;
        last_tot = d;
        push(EV_READY, cyc + 1, layer);
        if (last) push(EV_GAT, cyc + 2, layer);
      end
      tick();
    end
    fo = 1'b0;
    done = 1'b0;
  endtask

  task automatic after_nonfinal(input int layer);
    int p;
    tick();
    chk("gat_layer_increment", int'(gat_layer_o), layer + 1);
    chk("load_req_unload", int'(load_req_o), 1);
    // Stale load held high: the scheduler must keep requesting and not start.
    repeat ($urandom_range(1, 15)) tick();
    chk("load_req_stale", int'(load_req_o), 1);
    loads(3'b000);
    tick();
    repeat ($urandom_range(2, 8)) begin
      fo = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
      tick();
    end
    fo = 1'b0;
    done = 1'b0;
    tick();
    chk("spurious_dbg_latency", int'(dbg_latency_o), last_lat);
    chk("spurious_dbg_total", int'(dbg_total_o), last_tot);
    chk("spurious_load_req", int'(load_req_o), 1);
    p = $urandom_range(0, 2);
    loads(3'b111 ^ (3'b001 << p));
    repeat (6) tick();
    chk("partial_load_req", int'(load_req_o), 1);
    chk("partial_layer", int'(gat_layer_o), layer + 1);
  endtask

  task automatic after_final();
    tick();
    chk("gat_ready_rise", int'(gat_ready_o), 1);
    repeat (8) begin
      fo = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
      loads(3'($urandom_range(0, 7)));
      tick();
    end
    fo = 1'b0;
    done = 1'b0;
    chk("gat_ready_held", int'(gat_ready_o), 1);
    chk("no_error_after_done", int'(error_o), 0);
    chk("done_dbg_total_hold", int'(dbg_total_o), last_tot);
  endtask

  task automatic random_run();
    int d, f;
    do_reset();
    for (int l = 0; l < NL; l++) begin
      d = $urandom_range(1, 180);
      f = $urandom_range(0, d + 10);
      run_layer(l, f, d, l == NL - 1);
      if (l == NL - 1) after_final();
      else after_nonfinal(l);
    end
  endtask

  initial begin
    int t;
    do_reset();
    while (cyc < 10) tick();
    run_layer(0, 40, 100, 1'b0);
    after_nonfinal(0);
    run_layer(1, 40, 100, 1'b1);
    after_final();

    do_reset();
    run_layer(0, 57, 57, 1'b0);
    after_nonfinal(0);
    run_layer(1, 130, 120, 1'b1);
    after_final();

    repeat (3) random_run();

    // Timeout: no done ever arrives in RUN.
    do_reset();
    loads(3'b111);
    t = cyc;
    push(EV_START, t + 1, 0);
    push(EV_ERR, t + TO + 2, 0);
    repeat (TO + 6) tick();
    chk("timeout_error", int'(error_o), 1);
    chk("timeout_gat_ready", int'(gat_ready_o), 0);
    done = 1'b1;
    fo = 1'b1;
    tick();
    done = 1'b0;
    fo = 1'b0;
    repeat (4) tick();
    chk("err_sticky", int'(error_o), 1);
    chk("err_gat_ready_low", int'(gat_ready_o), 0);
    chk("err_dbg_total_hold", int'(dbg_total_o), last_tot);

    // Reset in the middle of RUN, then a fresh run from layer 0.
    do_reset();
    loads(3'b111);
    push(EV_START, cyc + 1, 0);
    repeat (35) tick();
    do_reset();
    run_layer(0, 12, 77, 1'b0);
    after_nonfinal(0);
    run_layer(1, 5, 33, 1'b1);
    after_final();

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
